// File: rtl/bus_bridge_slave.sv
// rtl/bus_bridge_slave.sv - serial bus slave forwarding transactions as UART byte frames
// Optional BB_SLAVE_SPLIT_EN: assert ssplit while a read waits for the remote reply.
module bus_bridge_slave #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       swdata,
  input  logic       smode,
  input  logic       mvalid,
  output logic       srdata,
  output logic       svalid,
  output logic       sready,
  output logic       ssplit,
  output logic [7:0] u_tx_data,
  output logic       u_tx_en,
  input  logic       u_tx_busy,
  input  logic [7:0] u_rx_data,
  input  logic       u_rx_ready
);

  typedef enum logic [3:0] {
    IDLE, ADDR, WDATA, TX_HDR, TX_ADDR_L, TX_ADDR_H, TX_DATA, RX_WAIT, RDATA
  } state_t;

  localparam logic [4:0] ADDR_LAST = 5'(ADDR_WIDTH - 1);
  localparam logic [4:0] DATA_LAST = 5'(DATA_WIDTH - 1);

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   addr_sr;
  logic [DATA_WIDTH-1:0]   wdata_sr;
  logic [DATA_WIDTH-1:0]   rdata_sr;
  logic                    mode;
  logic [4:0]              bit_cnt;
  logic [1:0]              hold;
  logic                    fire;
  logic                    can_fire;
  logic [7:0]              tx_byte;
  logic [15:0]             addr_ext;

  assign addr_ext = 16'(addr_sr);
  // hold covers the strobe cycle plus one more, so a late busy rise is not missed
  assign can_fire = (hold == 2'd0) && !u_tx_busy;
  assign sready   = (state == IDLE);

`ifdef BB_SLAVE_SPLIT_EN
  assign ssplit = (state == RX_WAIT);
`else
  assign ssplit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    fire       = 1'b0;
    tx_byte    = 8'h00;
    case (state)
      IDLE:    if (mvalid) state_next = ADDR;
      ADDR:    if (mvalid && bit_cnt == ADDR_LAST) state_next = mode ? WDATA : TX_HDR;
      WDATA:   if (mvalid && bit_cnt == DATA_LAST) state_next = TX_HDR;
      TX_HDR: begin
        tx_byte = {7'b0, mode};
        if (can_fire) begin
          fire       = 1'b1;
          state_next = TX_ADDR_L;
        end
      end
      TX_ADDR_L: begin
        tx_byte = addr_ext[7:0];
        if (can_fire) begin
          fire       = 1'b1;
          state_next = TX_ADDR_H;
        end
      end
      TX_ADDR_H: begin
        tx_byte = addr_ext[15:8];
        if (can_fire) begin
          fire       = 1'b1;
          state_next = mode ? TX_DATA : RX_WAIT;
        end
      end
      TX_DATA: begin
        tx_byte = 8'(wdata_sr);
        if (can_fire) begin
          fire       = 1'b1;
          state_next = IDLE;
        end
      end
      RX_WAIT: if (u_rx_ready) state_next = RDATA;
      RDATA:   if (bit_cnt == DATA_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_sr   <= '0;
      wdata_sr  <= '0;
      rdata_sr  <= '0;
      mode      <= 1'b0;
      bit_cnt   <= '0;
      hold      <= '0;
      srdata    <= 1'b0;
      svalid    <= 1'b0;
      u_tx_data <= 8'h00;
      u_tx_en   <= 1'b0;
    end else begin
      u_tx_en <= fire;
      if (fire) u_tx_data <= tx_byte;
      if (fire)              hold <= 2'd2;
      else if (hold != 2'd0) hold <= hold - 2'd1;
      case (state)
        IDLE: if (mvalid) begin
          addr_sr <= {swdata, addr_sr[ADDR_WIDTH-1:1]};
          mode    <= smode;
          bit_cnt <= 5'd1;
        end
        ADDR: if (mvalid) begin
          addr_sr <= {swdata, addr_sr[ADDR_WIDTH-1:1]};
          bit_cnt <= (bit_cnt == ADDR_LAST) ? 5'd0 : bit_cnt + 5'd1;
        end
        WDATA: if (mvalid) begin
          wdata_sr <= {swdata, wdata_sr[DATA_WIDTH-1:1]};
          bit_cnt  <= (bit_cnt == DATA_LAST) ? 5'd0 : bit_cnt + 5'd1;
        end
        RX_WAIT: if (u_rx_ready) begin
          rdata_sr <= u_rx_data >> 1;
          srdata   <= u_rx_data[0];
          svalid   <= 1'b1;
          bit_cnt  <= 5'd0;
        end
        RDATA: begin
          if (bit_cnt == DATA_LAST) begin
            srdata  <= 1'b0;
            svalid  <= 1'b0;
            bit_cnt <= 5'd0;
          end else begin
            srdata   <= rdata_sr[0];
            rdata_sr <= rdata_sr >> 1;
            bit_cnt  <= bit_cnt + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_bridge_slave.sv
// tb/tb_bus_bridge_slave.sv - scoreboard bench for bus_bridge_slave
module tb_bus_bridge_slave;

  logic       clk = 1'b0;
  logic       rstn;
  logic       swdata, smode, mvalid;
  logic       srdata, svalid, sready, ssplit;
  logic [7:0] u_tx_data;
  logic       u_tx_en;
  logic       u_tx_busy;
  logic [7:0] u_rx_data;
  logic       u_rx_ready;

`ifdef BB_SLAVE_SPLIT_EN
  localparam logic SPLIT = 1'b1;
`else
  localparam logic SPLIT = 1'b0;
`endif

  int         n_chk = 0;
  int         n_pass = 0;
  int         n_tx = 0;
  int         busy_len = 0;
  int         busy_cnt = 0;
  int         rcnt = 0;
  logic [7:0] rbyte;
  logic [7:0] tx_exp[$];
  logic [7:0] rd_exp[$];

  bus_bridge_slave #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) dut (
    .clk(clk), .rstn(rstn), .swdata(swdata), .smode(smode), .mvalid(mvalid),
    .srdata(srdata), .svalid(svalid), .sready(sready), .ssplit(ssplit),
    .u_tx_data(u_tx_data), .u_tx_en(u_tx_en), .u_tx_busy(u_tx_busy),
    .u_rx_data(u_rx_data), .u_rx_ready(u_rx_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
  endtask

  // UART transmitter model plus scoreboard consumers
  always @(negedge clk) begin
    if (!rstn) begin
      busy_cnt  = 0;
      u_tx_busy = 1'b0;
      rcnt      = 0;
    end else begin
      if (u_tx_en) begin
        if (u_tx_busy) chk("tx_en_while_busy", u_tx_busy, 1'b0);
        n_tx++;
        if (tx_exp.size() == 0) chk("tx_unexpected", u_tx_en, 1'b0);
        else chk("tx_byte", u_tx_data, tx_exp.pop_front());
        busy_cnt = busy_len;
      end
      u_tx_busy = (busy_cnt > 0);
      if (busy_cnt > 0) busy_cnt--;
      if (svalid) begin
        if (rd_exp.size() == 0) chk("svalid_unexpected", svalid, 1'b0);
        else begin
          rbyte[rcnt[2:0]] = srdata;
          rcnt++;
          if (rcnt == 8) begin
            chk("rd_byte", rbyte, rd_exp.pop_front());
            rcnt = 0;
          end
        end
      end else if (rcnt != 0) begin
        chk("svalid_len", rcnt, 8);
        rcnt = 0;
      end
    end
  end

  task automatic send_bits(input logic [15:0] v, input int n, input bit gaps,
                           input bit md, input bit first);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (first && i == 1) chk("sready_fall", sready, 1'b0);
      mvalid = 1'b1;
      swdata = v[i];
      smode  = (first && i == 0) ? md : ~md;
      if (gaps && (i % 3 == 2)) begin
        @(negedge clk);
        mvalid = 1'b0;
        swdata = ~swdata;
        @(negedge clk);
      end
    end
  endtask

  task automatic wait_tx_drained(input int budget);
    int k = 0;
    while ((tx_exp.size() != 0 || !sready) && k < budget) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic do_write(input logic [11:0] a, input logic [7:0] d, input bit gaps);
    int start = n_tx;
    tx_exp.push_back(8'h01);
    tx_exp.push_back(a[7:0]);
    tx_exp.push_back({4'h0, a[11:8]});
    tx_exp.push_back(d);
    send_bits({4'h0, a}, 12, gaps, 1'b1, 1'b1);
    send_bits({8'h00, d}, 8, gaps, 1'b1, 1'b0);
    @(negedge clk);
    mvalid = 1'b0;
    wait_tx_drained(2000);
    chk("wr_frame_left", tx_exp.size(), 0);
    chk("wr_sready", sready, 1'b1);
    chk("wr_pulses", n_tx - start, 4);
  endtask

  task automatic do_read(input logic [11:0] a, input logic [7:0] d);
    int k = 0;
    tx_exp.push_back(8'h00);
    tx_exp.push_back(a[7:0]);
    tx_exp.push_back({4'h0, a[11:8]});
    rd_exp.push_back(d);
    send_bits({4'h0, a}, 12, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    mvalid = 1'b0;
    while (tx_exp.size() != 0 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("rd_frame_left", tx_exp.size(), 0);
    repeat (6) @(negedge clk);
    chk("rx_wait_ssplit", ssplit, SPLIT);
    chk("rx_wait_svalid", svalid, 1'b0);
    chk("rx_wait_sready", sready, 1'b0);
    u_rx_ready = 1'b1;
    u_rx_data  = d;
    @(negedge clk);
    u_rx_ready = 1'b0;
    u_rx_data  = 8'($urandom);
    chk("svalid_rise", svalid, 1'b1);
    chk("rdata_ssplit", ssplit, 1'b0);
    k = 0;
    while (svalid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("rd_svalid_fall", svalid, 1'b0);
    chk("rd_sready", sready, 1'b1);
    chk("rd_exp_left", rd_exp.size(), 0);
  endtask

  initial begin
    int start;
    int k;
    rstn = 1'b0; swdata = 1'b0; smode = 1'b0; mvalid = 1'b0;
    u_rx_data = 8'h00; u_rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_sready", sready, 1'b1);
    chk("rst_svalid", svalid, 1'b0);
    chk("rst_srdata", srdata, 1'b0);
    chk("rst_ssplit", ssplit, 1'b0);
    chk("rst_tx_en", u_tx_en, 1'b0);
    chk("rst_tx_data", u_tx_data, 8'h00);

    do_write(12'h5A3, 8'hC7, 1'b0);
    busy_len = 20;
    do_write(12'h5A3, 8'hC7, 1'b1);
    busy_len = 0;
    do_write(12'hFFF, 8'h00, 1'b0);
    do_read(12'h0FF, 8'h3C);

    @(negedge clk);
    u_rx_ready = 1'b1;
    u_rx_data  = 8'hAA;
    @(negedge clk);
    u_rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_rx_svalid", svalid, 1'b0);
    chk("idle_rx_sready", sready, 1'b1);
    do_read(12'h001, 8'h55);

    // abandon a write while stalled in the address-low byte
    busy_len = 20;
    start = n_tx;
    tx_exp.push_back(8'h01);
    send_bits(16'h05A3, 12, 1'b0, 1'b1, 1'b1);
    send_bits(16'h00C7, 8, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    mvalid = 1'b0;
    k = 0;
    while (tx_exp.size() != 0 && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("rst_hdr_sent", tx_exp.size(), 0);
    repeat (3) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("async_sready", sready, 1'b1);
    chk("async_tx_en", u_tx_en, 1'b0);
    chk("async_tx_data", u_tx_data, 8'h00);
    chk("async_svalid", svalid, 1'b0);
    chk("async_ssplit", ssplit, 1'b0);
    tx_exp.delete();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    busy_len = 0;
    repeat (60) @(negedge clk);
    chk("rst_no_more_tx", n_tx - start, 1);
    do_read(12'h0FF, 8'h3C);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bus_bridge_slave.md
# bus_bridge_slave

Target-side end of the board-to-board bus bridge: acts as a slave on the bit-serial system bus, collects each serial read/write transaction and forwards it as a UART byte frame to the remote board. For reads it waits for the remote data byte on the UART receive path and shifts it back onto the serial bus. It connects to the bus like any slave port and to a `uart` instance through byte-wide transmit and receive handshakes.

## Interface
- `ADDR_WIDTH`, 12, slave address bits received serially; 9..16 supported.
- `DATA_WIDTH`, 8, serial data bits; fixed to 8, one UART byte.
- `clk`  in  1  single clock.
- `rstn`  in  1  reset, asynchronous, active-low.
- `swdata`  in  1  serial address/write data from bus, LSB first.
- `smode`  in  1  0 read, 1 write; sampled with the first address bit.
- `mvalid`  in  1  `swdata` bit valid.
- `srdata`  out  1  serial read data, LSB first.
- `svalid`  out  1  `srdata` bit valid.
- `sready`  out  1  slave idle, able to accept a transaction.
- `ssplit`  out  1  read outstanding, bus may be released (see Configuration).
- `u_tx_data`  out  8  byte to UART transmitter.
- `u_tx_en`  out  1  one-cycle transmit strobe.
- `u_tx_busy`  in  1  UART transmitter busy.
- `u_rx_data`  in  8  byte from UART receiver.
- `u_rx_ready`  in  1  one-cycle strobe, `u_rx_data` valid.

## Operation
- States: IDLE, ADDR, WDATA, TX_HDR, TX_ADDR_L, TX_ADDR_H, TX_DATA, RX_WAIT, RDATA.
- IDLE: `sready`=1. First `mvalid` cycle captures `swdata` as address bit 0 and latches `smode`; go to ADDR.
- ADDR: shift one bit per `mvalid` cycle; gaps in `mvalid` are allowed and not counted. After `ADDR_WIDTH` bits: write -> WDATA, read -> TX_HDR.
- WDATA: `DATA_WIDTH` more `mvalid` bits, then TX_HDR.
- Frame out: header byte (0x01 write, 0x00 read), address low byte, address high byte (zero-extended), then data byte for writes only.
- Each TX_* state waits for `u_tx_busy`=0, drives `u_tx_data`, pulses `u_tx_en` for one cycle, then ignores `u_tx_busy` for one cycle before waiting on it again.
- After last byte: write -> IDLE; read -> RX_WAIT.
- RX_WAIT: on `u_rx_ready` latch `u_rx_data`, go to RDATA. `u_rx_ready` in any other state is ignored.
- RDATA: drive `DATA_WIDTH` consecutive cycles with `svalid`=1, `srdata`=bit i, LSB first; then IDLE.
- `mvalid` outside IDLE/ADDR/WDATA is ignored.

## Timing
- Reset values: `srdata`=0, `svalid`=0, `sready`=1, `ssplit`=0, `u_tx_data`=0x00, `u_tx_en`=0; state IDLE, counters cleared.
- Reset mid-transaction: abandons it immediately; no further UART bytes issued; partial frame is not completed.
- `sready` falls the cycle after the first accepted bit; rises the cycle the state returns to IDLE.
- First `u_tx_en` no earlier than one cycle after the final serial bit.
- Read return: `svalid` rises the cycle after `u_rx_ready`; high exactly 8 cycles, then `sready`=1 next cycle.
- Write with idle UART: four `u_tx_en` pulses, each gated by `u_tx_busy` low.
- `u_tx_busy` held high: block stalls indefinitely in current TX_* state, `u_tx_en` stays 0.

## Configuration
- `BB_SLAVE_SPLIT_EN` defined: `ssplit`=1 from RX_WAIT entry until the cycle RDATA is entered, so the arbiter can release the bus during the remote round trip; RDATA starts only after `u_rx_ready`, independent of grant.
- Not defined: `ssplit` is constant 0; all other behaviour identical.

## Test plan
- Write addr 0x5A3, data 0xC7, UART idle -> bytes 0x01, 0xA3, 0x05, 0xC7 on `u_tx_data`, four `u_tx_en` pulses, `sready` back to 1, `svalid` never asserted.
- Read addr 0x0FF, `u_rx_data`=0x3C strobed later -> bytes 0x00, 0xFF, 0x00; `srdata` 0,0,1,1,1,1,0,0 with `svalid` high 8 cycles.
- Write with `mvalid` gaps (2 idle cycles every 3 bits) and `u_tx_busy` high 20 cycles per byte -> same frame as uninterrupted, no strobe while busy.
- `u_rx_ready` pulse with 0xAA in IDLE, then read addr 0x001 answered 0x55 -> returned data 0x55, 0xAA discarded.
- `rstn` low during TX_ADDR_L of a write -> all outputs at reset values asynchronously, no further `u_tx_en`; next read transaction completes normally.
- With `BB_SLAVE_SPLIT_EN`: read -> `ssplit`=1 throughout RX_WAIT, 0 in RDATA; without: `ssplit` constant 0.
